// File: rtl/gate_g_seq_if.sv
// Handshake and serial-output bundle between the burst controller and its
// upstream requester. The requester drives the program; the serialiser drives
// the gated-stage outputs.
interface gate_g_seq_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8,
    parameter int IDX_W  = 4
);
    logic              start;
    logic              abort;
    logic [DATA_W-1:0] data_in;
    logic [CNT_W-1:0]  open_len;
    logic [CNT_W-1:0]  gap_len;
    logic [IDX_W-1:0]  nbits;
    logic              d;
    logic              enable;
    logic              busy;
    logic              done;
    logic [IDX_W-1:0]  bit_idx;

    modport master (
        output start, abort, data_in, open_len, gap_len, nbits,
        input  d, enable, busy, done, bit_idx
    );

    modport slave (
        input  start, abort, data_in, open_len, gap_len, nbits,
        output d, enable, busy, done, bit_idx
    );
endinterface

// File: rtl/gate_g_seq.sv
// Burst serialiser feeding a gated D storage stage. A start in IDLE latches a
// word and a timing program; the word is then presented LSB-first, one bit per
// enable window of programmable length, with programmable gaps in between,
// and the burst ends with a one-cycle done pulse. Outputs are registered from
// the next state, and a one-cycle launch flag after the accepted start gives
// the fixed start-to-first-window latency.
module gate_g_seq #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8,
    parameter int IDX_W  = 4
) (
    input  logic         clk,
    input  logic         rst,
    gate_g_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]  IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(DATA_W);
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    state_t            state_r;
    state_t            next_state_s;
    logic              pending_r;
    logic [DATA_W-1:0] data_sh_r;
    logic [DATA_W-1:0] next_sh_s;
    logic [CNT_W-1:0]  open_r;
    logic [CNT_W-1:0]  gap_r;
    logic [IDX_W-1:0]  nbits_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  next_cnt_s;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  next_idx_s;
    logic              accept_s;
    logic              last_bit_s;
    logic [CNT_W-1:0]  eff_open_s;
    logic [IDX_W-1:0]  eff_nbits_s;

    logic              d_r;
    logic              enable_r;
    logic              busy_r;
    logic              done_r;
    logic [IDX_W-1:0]  bit_idx_r;

    // start is only taken in a settled IDLE (not in the launch cycle)
    assign accept_s    = (state_r == IDLE) && !pending_r && bus.start;
    assign eff_open_s  = (bus.open_len == CNT_ZERO) ? CNT_ONE : bus.open_len;
    assign eff_nbits_s = (bus.nbits > IDX_MAX) ? IDX_MAX : bus.nbits;
    assign last_bit_s  = (idx_r == (nbits_r - IDX_ONE));

    // Next-state, window/gap counter, bit index and data shifter
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        next_idx_s   = idx_r;
        next_sh_s    = data_sh_r;
        case (state_r)
            IDLE: begin
                if (pending_r) begin
                    if (nbits_r == IDX_ZERO) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = OPEN;
                        next_idx_s   = IDX_ZERO;
                        next_cnt_s   = open_r - CNT_ONE;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            OPEN: begin
                if (bus.abort) begin
                    next_state_s = IDLE;
                end else if (cnt_r != CNT_ZERO) begin
                    next_cnt_s = cnt_r - CNT_ONE;
                end else if (last_bit_s) begin
                    next_state_s = DONE;
                end else if (gap_r == CNT_ZERO) begin
                    // back-to-back windows: enable stays high, next bit shown
                    next_idx_s = idx_r + IDX_ONE;
                    next_sh_s  = {1'b0, data_sh_r[DATA_W-1:1]};
                    next_cnt_s = open_r - CNT_ONE;
                end else begin
                    next_state_s = GAP;
                    next_cnt_s   = gap_r - CNT_ONE;
                end
            end
            GAP: begin
                if (bus.abort) begin
                    next_state_s = IDLE;
                end else if (cnt_r != CNT_ZERO) begin
                    next_cnt_s = cnt_r - CNT_ONE;
                end else begin
                    next_state_s = OPEN;
                    next_idx_s   = idx_r + IDX_ONE;
                    next_sh_s    = {1'b0, data_sh_r[DATA_W-1:1]};
                    next_cnt_s   = open_r - CNT_ONE;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, counters and latched program
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            pending_r <= 1'b0;
            cnt_r     <= CNT_ZERO;
            idx_r     <= IDX_ZERO;
            data_sh_r <= DATA_ZERO;
            open_r    <= CNT_ZERO;
            gap_r     <= CNT_ZERO;
            nbits_r   <= IDX_ZERO;
        end else begin
            state_r   <= next_state_s;
            pending_r <= accept_s;
            cnt_r     <= next_cnt_s;
            idx_r     <= next_idx_s;
            if (accept_s) begin
                data_sh_r <= bus.data_in;
                open_r    <= eff_open_s;
                gap_r     <= bus.gap_len;
                nbits_r   <= eff_nbits_s;
            end else begin
                data_sh_r <= next_sh_s;
            end
        end
    end

    // Registered outputs derived from the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_r       <= 1'b0;
            enable_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            bit_idx_r <= IDX_ZERO;
        end else begin
            enable_r  <= (next_state_s == OPEN);
            busy_r    <= (next_state_s == OPEN) || (next_state_s == GAP);
            done_r    <= (next_state_s == DONE);
            bit_idx_r <= next_idx_s;
            if (next_state_s == OPEN) begin
                d_r <= next_sh_s[0];
            end else begin
                d_r <= d_r;
            end
        end
    end

    assign bus.d       = d_r;
    assign bus.enable  = enable_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.bit_idx = bit_idx_r;
endmodule

// File: tb/tb_gate_g_seq.sv
// Bench for gate_g_seq: a queue-based model expands every accepted start into
// the per-cycle output sequence implied by the burst rules, and one compare
// process checks the outputs against it on every cycle. Directed bursts pin
// the model with hand-computed latencies, window counts and bit patterns;
// a randomized phase then exercises starts, aborts and program values.
module tb_gate_g_seq;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;
    localparam int IDX_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gate_g_seq_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .IDX_W(IDX_W)) bus();

    gate_g_seq #(.DATA_W(DATA_W), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       en;
        logic       bs;
        logic       dn;
        logic       hold;
        logic       dv;
        logic [3:0] idx;
    } rec_t;

    rec_t q[$];
    int   checks   = 0;
    int   failures = 0;
    logic d_last   = 1'b0;
    bit   prev_idle = 1'b1;
    bit   prev_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rec_t mk(logic en, logic bs, logic dn, logic hold, logic dv, logic [3:0] idx);
        rec_t r;
        r.en = en; r.bs = bs; r.dn = dn; r.hold = hold; r.dv = dv; r.idx = idx;
        return r;
    endfunction

    // Expand one accepted program into its cycle-by-cycle expected outputs
    function automatic void push_burst(logic [7:0] data, logic [7:0] ol, logic [7:0] gl, logic [3:0] nb);
        int n = (int'(nb) > DATA_W) ? DATA_W : int'(nb);
        int l = (ol == 8'd0) ? 1 : int'(ol);
        logic [7:0] sh;
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0));
        for (int b = 0; b < n; b++) begin
            sh = data >> b;
            for (int c = 0; c < l; c++) q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, sh[0], 4'(b)));
            if (b < n - 1)
                for (int c = 0; c < int'(gl); c++) q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'(b)));
        end
        q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0));
    endfunction

    // Model: react to start/abort as sampled on the rising edge
    always @(posedge clk) begin
        if (!rst) begin
            if (prev_idle && bus.start) push_burst(bus.data_in, bus.open_len, bus.gap_len, bus.nbits);
            else if (prev_busy && bus.abort) q.delete();
        end
    end

    // Compare: every cycle, DUT outputs against the model's expected record
    always @(negedge clk) begin
        rec_t r;
        if (!rst) begin
            if (q.size() == 0) begin
                check("idle_enable", 32'(bus.enable), 32'd0);
                check("idle_busy",   32'(bus.busy),   32'd0);
                check("idle_done",   32'(bus.done),   32'd0);
                check("idle_d",      32'(bus.d),      32'(d_last));
                prev_idle = 1'b1;
                prev_busy = 1'b0;
            end else begin
                r = q.pop_front();
                check("cyc_enable", 32'(bus.enable), 32'(r.en));
                check("cyc_busy",   32'(bus.busy),   32'(r.bs));
                check("cyc_done",   32'(bus.done),   32'(r.dn));
                check("cyc_d",      32'(bus.d),      r.hold ? 32'(d_last) : 32'(r.dv));
                if (r.bs) check("cyc_bit_idx", 32'(bus.bit_idx), 32'(r.idx));
                if (!r.hold) d_last = r.dv;
                prev_idle = 1'b0;
                prev_busy = r.bs;
            end
        end
    end

    task automatic model_clear();
        q.delete();
        d_last    = 1'b0;
        prev_idle = 1'b1;
        prev_busy = 1'b0;
    endtask

    // One burst from a settled IDLE; measures latency, windows and captured bits
    task automatic run_burst(input logic [7:0] data, input logic [7:0] ol, input logic [7:0] gl,
                             input logic [3:0] nb, input int abort_win, input int mid_start_k,
                             output int lat, output int en_cnt, output int busy_cnt,
                             output logic [7:0] cap, output int windows, output bit seen_done);
        bit aborted = 1'b0;
        bit abort_chk = 1'b0;
        int after_abort = 0;
        logic prev_en = 1'b0;
        logic [3:0] prev_idx = 4'd0;
        lat = -1; en_cnt = 0; busy_cnt = 0; cap = 8'd0; windows = 0; seen_done = 1'b0;
        @(negedge clk); #1;
        bus.data_in = data; bus.open_len = ol; bus.gap_len = gl; bus.nbits = nb; bus.start = 1'b1;
        @(negedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            if (abort_chk) begin
                check("abort_enable", 32'(bus.enable), 32'd0);
                check("abort_busy",   32'(bus.busy),   32'd0);
                abort_chk = 1'b0;
            end
            if (aborted) after_abort++;
            if (bus.enable) en_cnt++;
            if (bus.busy) busy_cnt++;
            if (bus.enable && (!prev_en || bus.bit_idx != prev_idx)) begin
                windows++;
                cap = cap | (8'(bus.d) << bus.bit_idx);
                if (windows == abort_win) begin
                    bus.abort = 1'b1;
                    aborted = 1'b1;
                    abort_chk = 1'b1;
                end
            end
            if (bus.done && !seen_done) begin
                lat = k - 1;
                seen_done = 1'b1;
            end
            prev_en = bus.enable;
            prev_idx = bus.bit_idx;
            if (k == mid_start_k) begin
                bus.data_in = 8'h5A; bus.open_len = 8'd1; bus.gap_len = 8'd0; bus.nbits = 4'd3;
                bus.start = 1'b1;
            end
            if (seen_done || after_abort > 30) break;
            @(negedge clk); #1;
            bus.start = 1'b0;
            bus.abort = 1'b0;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    initial begin
        int lat, en_cnt, busy_cnt, windows;
        logic [7:0] cap;
        bit seen_done;
        bit found;
        bus.start = 1'b0; bus.abort = 1'b0; bus.data_in = 8'd0;
        bus.open_len = 8'd0; bus.gap_len = 8'd0; bus.nbits = 4'd0;

        // reset state
        #1 rst = 1'b1;
        #1;
        check("reset_enable",  32'(bus.enable),  32'd0);
        check("reset_busy",    32'(bus.busy),    32'd0);
        check("reset_done",    32'(bus.done),    32'd0);
        check("reset_d",       32'(bus.d),       32'd0);
        check("reset_bit_idx", 32'(bus.bit_idx), 32'd0);
        model_clear();
        @(negedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // A5, L=2, G=3, N=8, with an ignored second start at burst midpoint
        run_burst(8'hA5, 8'd2, 8'd3, 4'd8, 0, 19, lat, en_cnt, busy_cnt, cap, windows, seen_done);
        check("t1_done_seen", 32'(seen_done), 32'd1);
        check("t1_latency",   32'(lat),       32'd38);
        check("t1_windows",   32'(windows),   32'd8);
        check("t1_en_cycles", 32'(en_cnt),    32'd16);
        check("t1_busy_cyc",  32'(busy_cnt),  32'd37);
        check("t1_bits",      32'(cap),       32'hA5);

        // gap 0: back-to-back single-cycle windows
        run_burst(8'b0000_0110, 8'd1, 8'd0, 4'd4, 0, 0, lat, en_cnt, busy_cnt, cap, windows, seen_done);
        check("t2_latency",   32'(lat),     32'd5);
        check("t2_windows",   32'(windows), 32'd4);
        check("t2_en_cycles", 32'(en_cnt),  32'd4);
        check("t2_bits",      32'(cap),     32'h06);

        // nbits 0: done only
        run_burst(8'hFF, 8'd3, 8'd3, 4'd0, 0, 0, lat, en_cnt, busy_cnt, cap, windows, seen_done);
        check("t3_latency",   32'(lat),      32'd1);
        check("t3_en_cycles", 32'(en_cnt),   32'd0);
        check("t3_busy_cyc",  32'(busy_cnt), 32'd0);

        // open_len 0 -> 1, nbits 12 -> 8
        run_burst(8'h3C, 8'd0, 8'd2, 4'd12, 0, 0, lat, en_cnt, busy_cnt, cap, windows, seen_done);
        check("t4_latency",   32'(lat),     32'd23);
        check("t4_windows",   32'(windows), 32'd8);
        check("t4_en_cycles", 32'(en_cnt),  32'd8);
        check("t4_bits",      32'(cap),     32'h3C);

        // abort in the 3rd window, then a clean burst from bit 0
        run_burst(8'hC3, 8'd2, 8'd1, 4'd8, 3, 0, lat, en_cnt, busy_cnt, cap, windows, seen_done);
        check("t5_no_done",  32'(seen_done), 32'd0);
        check("t5_windows",  32'(windows),   32'd3);
        check("t5_bits",     32'(cap),       32'h03);
        run_burst(8'h96, 8'd1, 8'd1, 4'd8, 0, 0, lat, en_cnt, busy_cnt, cap, windows, seen_done);
        check("t5b_latency", 32'(lat),     32'd16);
        check("t5b_bits",    32'(cap),     32'h96);

        // async reset in the middle of a gap, between clock edges
        @(negedge clk); #1;
        bus.data_in = 8'hA5; bus.open_len = 8'd2; bus.gap_len = 8'd3; bus.nbits = 4'd8; bus.start = 1'b1;
        @(negedge clk); #1 bus.start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (bus.busy && !bus.enable) begin
                found = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        check("t6_gap_reached", 32'(found), 32'd1);
        #2 rst = 1'b1;
        model_clear();
        #1;
        check("t6_rst_enable",  32'(bus.enable),  32'd0);
        check("t6_rst_busy",    32'(bus.busy),    32'd0);
        check("t6_rst_done",    32'(bus.done),    32'd0);
        check("t6_rst_d",       32'(bus.d),       32'd0);
        check("t6_rst_bit_idx", 32'(bus.bit_idx), 32'd0);
        @(negedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        run_burst(8'h81, 8'd1, 8'd2, 4'd8, 0, 0, lat, en_cnt, busy_cnt, cap, windows, seen_done);
        check("t6b_latency", 32'(lat), 32'd23);
        check("t6b_bits",    32'(cap), 32'h81);

        // randomized starts, aborts and programs against the model
        repeat (3000) begin
            @(negedge clk); #1;
            bus.start    = ($urandom_range(0, 5) == 0);
            bus.abort    = ($urandom_range(0, 59) == 0);
            bus.data_in  = 8'($urandom);
            bus.open_len = 8'($urandom_range(0, 3));
            bus.gap_len  = 8'($urandom_range(0, 3));
            bus.nbits    = 4'($urandom_range(0, 10));
        end
        @(negedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (200) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/gate_g_seq.md
Name: gate_g_seq

Overview:
- Upstream driver for the gated D storage stage: generates its `d` and `enable` inputs.
- Latches a data word and a timing program on a start handshake.
- Serialises the word LSB-first, one bit per enable window, with a programmable window length and inter-window gap.
- Signals completion with a one-cycle done pulse, so the downstream gated stage captures each bit in turn.

Parameters:
- DATA_W, 8, width of the word to serialise (max bits per burst).
- CNT_W, 8, width of the window and gap length counters.
- IDX_W, 4, width of the bit-count and bit-index fields; must satisfy 2^IDX_W > DATA_W.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only in IDLE.
- abort  input  1  synchronous cancel of the current burst.
- data_in  input  DATA_W  word to serialise; latched on accepted start.
- open_len  input  CNT_W  enable-high cycles per window; latched on accepted start.
- gap_len  input  CNT_W  enable-low cycles between windows; latched on accepted start.
- nbits  input  IDX_W  number of bits/windows; latched on accepted start.
- d  output  1  data bit to gated stage.
- enable  output  1  enable to gated stage.
- busy  output  1  burst in progress.
- done  output  1  one-cycle completion pulse.
- bit_idx  output  IDX_W  index of the bit currently presented.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is asynchronous and active-high: rst=1 immediately forces state IDLE.
  - On reset, d=0, enable=0, busy=0, done=0, bit_idx=0, all counters and latched registers 0.
  - Reset mid-burst abandons the burst; no done is produced.
- Outputs: all registered, no combinational input-to-output paths.
- States: IDLE, OPEN, GAP, DONE.
- IDLE:
  - enable=0, busy=0; d holds its last value.
  - On the edge where start=1, latch data_in, open_len, gap_len and nbits.
  - Latch rules:
    - open_len=0 is treated as 1.
    - nbits>DATA_W is clamped to DATA_W.
  - If the effective nbits=0, go to DONE. Otherwise go to OPEN with bit_idx=0.
- OPEN:
  - enable=1, busy=1, d=data[bit_idx], all from the first cycle of the state.
  - Enable is high for exactly L=effective open_len cycles.
  - After the L-th cycle:
    - if bit_idx is the last bit, go to DONE;
    - else if gap_len=0, start the next window directly (enable stays 1, d updates, bit_idx increments);
    - else go to GAP.
- GAP:
  - enable=0, busy=1, d holds the bit just presented.
  - After gap_len cycles, go to OPEN with bit_idx+1.
  - No trailing gap follows the last window.
- DONE:
  - done=1 and busy=0 for exactly one cycle, enable=0; then IDLE.
  - start is not accepted in DONE.
- Latency: start sampled at edge T gives enable=1 and d=data_in[0] visible after edge T+1.
- Total burst: done is high in cycle T+1+N*L+(N-1)*G for N≥1. For N=0, done is high in cycle T+1.
- start while busy or in DONE is ignored; the latched program is unaffected.
- abort=1 in OPEN or GAP: next edge gives IDLE, enable=0, busy=0, no done. abort in IDLE or DONE has no effect.
- Simultaneous start and abort in IDLE: start wins.
- Counters: down-counters of CNT_W bits; no wrap is possible because each is reloaded per window or gap.
- Maximum values: open_len=2^CNT_W-1 is legal. bit_idx never exceeds nbits-1.

Test Plan:
- Reset, then start with data_in=8'hA5, open_len=2, gap_len=3, nbits=8. Required response:
  - enable high in 8 windows of 2 cycles, separated by 3-cycle gaps;
  - d sequence 1,0,1,0,0,1,0,1;
  - done pulses exactly once, 1+8*2+7*3=38 cycles after start;
  - busy low in the done cycle.
- gap_len=0, open_len=1, nbits=4, data_in=4'b0110 -> enable high for 4 consecutive cycles; d=0,1,1,0; done on the next cycle.
- nbits=0 -> enable never asserts; done one cycle after start; busy never asserts.
- open_len=0 and nbits=12 with DATA_W=8 -> treated as open_len=1 and 8 windows.
- abort asserted during the 3rd window -> enable=0 and busy=0 the next cycle; done stays 0. A new start then runs normally from bit 0.
- Async reset asserted mid-GAP, between clock edges -> all outputs 0 immediately. start held high during the burst is ignored (checked with a second start pulse at burst midpoint).
